// File: rtl/gmii_link_emulator.sv
// rtl/gmii_link_emulator.sv - N-port GMII link emulator with per-port programmable delay lines
//
// Routes each port's transmit stream to a partner port's receive side, either
// crossover (2k <-> 2k+1) or self-loopback, through a circular delay buffer.
// Total latency from tx_* to rx_* is 1 + delay_act cycles.
//
// Optional feature macro: GMII_LINK_EMU_ERR_INJ_EN
//   Adds inj_req / err_cnt ports; a requested error flips bit 0 of byte 8 of
//   the next received frame on that port and raises rx_er for that byte.
//
// Ports:
//   clk            single clock for all ports
//   resetn         asynchronous active-low reset
//   tx_data/en/er  per-port GMII transmit side (port i at [i*DATA_W +: DATA_W])
//   rx_data/dv/er  per-port GMII receive side (registered)
//   cfg_pair_mode  0: crossover, 1: self-loopback (applied only while idle)
//   cfg_delay      extra latency in cycles (applied only while idle)
//   cfg_link_up    per-source link enable (applied only between frames)
//   frame_cnt      per-port saturating received-frame counters
//   busy           any frame in flight anywhere
//   inj_req        (macro) per-destination error injection request pulse
//   err_cnt        (macro) per-port saturating injected-error counters
module gmii_link_emulator #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_DELAY = 16,
    parameter int CNT_W     = 32
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_PORTS*DATA_W-1:0]    tx_data,
    input  logic [NUM_PORTS-1:0]           tx_en,
    input  logic [NUM_PORTS-1:0]           tx_er,
    output logic [NUM_PORTS*DATA_W-1:0]    rx_data,
    output logic [NUM_PORTS-1:0]           rx_dv,
    output logic [NUM_PORTS-1:0]           rx_er,
    input  logic                           cfg_pair_mode,
    input  logic [$clog2(MAX_DELAY)-1:0]   cfg_delay,
    input  logic [NUM_PORTS-1:0]           cfg_link_up,
    output logic [NUM_PORTS*CNT_W-1:0]     frame_cnt,
`ifdef GMII_LINK_EMU_ERR_INJ_EN
    input  logic [NUM_PORTS-1:0]           inj_req,
    output logic [NUM_PORTS*CNT_W-1:0]     err_cnt,
`endif
    output logic                           busy
);

    localparam int PTR_W = $clog2(MAX_DELAY);

    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_delay_act;
    logic                 r_mode_act;
    logic [NUM_PORTS-1:0] r_link_act;

    // Delay line storage, indexed by source port
    logic [DATA_W-1:0]    r_mem_data [NUM_PORTS][MAX_DELAY];
    logic [MAX_DELAY-1:0] r_mem_en   [NUM_PORTS];
    logic [MAX_DELAY-1:0] r_mem_er   [NUM_PORTS];

    logic [PTR_W-1:0]            w_rd_ptr;
    logic [NUM_PORTS-1:0]        w_wr_en;
    logic [NUM_PORTS-1:0]        w_wr_er;
    logic                        w_stored_any;
    logic [NUM_PORTS*DATA_W-1:0] w_sel_data;
    logic [NUM_PORTS-1:0]        w_sel_dv;
    logic [NUM_PORTS-1:0]        w_sel_er;
    logic [NUM_PORTS*DATA_W-1:0] w_nxt_data;
    logic [NUM_PORTS-1:0]        w_nxt_dv;
    logic [NUM_PORTS-1:0]        w_nxt_er;

    function automatic int src_port(input int dst, input logic mode);
        return mode ? dst : (dst ^ 1);
    endfunction

    assign w_rd_ptr = r_wr_ptr - r_delay_act;
    // A downed link still writes data, but never frame flags
    assign w_wr_en  = tx_en & r_link_act;
    assign w_wr_er  = tx_er & r_link_act;

    always_comb begin
        w_stored_any = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_stored_any = w_stored_any | (|r_mem_en[p]);
        end
    end

    assign busy = (|tx_en) | (|rx_dv) | w_stored_any;

    // Zero delay bypasses the buffer so the output register alone gives one cycle
    always_comb begin
        w_sel_data = '0;
        w_sel_dv   = '0;
        w_sel_er   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_delay_act == '0) begin
                w_sel_data[i*DATA_W +: DATA_W] = tx_data[src_port(i, r_mode_act)*DATA_W +: DATA_W];
                w_sel_dv[i] = w_wr_en[src_port(i, r_mode_act)];
                w_sel_er[i] = w_wr_er[src_port(i, r_mode_act)];
            end else begin
                w_sel_data[i*DATA_W +: DATA_W] = r_mem_data[src_port(i, r_mode_act)][w_rd_ptr];
                w_sel_dv[i] = r_mem_en[src_port(i, r_mode_act)][w_rd_ptr];
                w_sel_er[i] = r_mem_er[src_port(i, r_mode_act)][w_rd_ptr];
            end
        end
    end

`ifdef GMII_LINK_EMU_ERR_INJ_EN
    logic [NUM_PORTS-1:0] r_inj_pend;
    logic [3:0]           r_byte_idx [NUM_PORTS];
    logic [3:0]           w_idx      [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_inj_hit;

    // w_idx is the in-frame index of the byte about to be output; it saturates
    // so index 8 is hit at most once per frame
    always_comb begin
        w_nxt_data = w_sel_data;
        w_nxt_dv   = w_sel_dv;
        w_nxt_er   = w_sel_er;
        w_inj_hit  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rx_dv[i]) begin
                w_idx[i] = (r_byte_idx[i] == 4'hF) ? 4'hF : r_byte_idx[i] + 4'd1;
            end else begin
                w_idx[i] = 4'd0;
            end
            w_inj_hit[i] = r_inj_pend[i] & w_sel_dv[i] & (w_idx[i] == 4'd8);
            w_nxt_data[i*DATA_W] = w_sel_data[i*DATA_W] ^ w_inj_hit[i];
            w_nxt_er[i] = w_sel_er[i] | w_inj_hit[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inj_pend <= '0;
            err_cnt    <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_byte_idx[p] <= '0;
            end
        end else begin
            // A request arriving on the hit cycle stays pending for the next frame
            r_inj_pend <= (r_inj_pend & ~w_inj_hit) | inj_req;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_byte_idx[p] <= w_idx[p];
                if (w_inj_hit[p] && err_cnt[p*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
                    err_cnt[p*CNT_W +: CNT_W] <= err_cnt[p*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end
`else
    assign w_nxt_data = w_sel_data;
    assign w_nxt_dv   = w_sel_dv;
    assign w_nxt_er   = w_sel_er;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr    <= '0;
            r_delay_act <= '0;
            r_mode_act  <= 1'b0;
            r_link_act  <= '0;
            rx_data     <= '0;
            rx_dv       <= '0;
            rx_er       <= '0;
            frame_cnt   <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_mem_en[p] <= '0;
                r_mem_er[p] <= '0;
            end
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            // Routing/latency only change with nothing in flight, so no frame is split
            if (!busy) begin
                r_delay_act <= cfg_delay;
                r_mode_act  <= cfg_pair_mode;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!tx_en[p]) begin
                    r_link_act[p] <= cfg_link_up[p];
                end
                r_mem_en[p][r_wr_ptr] <= w_wr_en[p];
                r_mem_er[p][r_wr_ptr] <= w_wr_er[p];
                rx_data[p*DATA_W +: DATA_W] <= (w_nxt_dv[p] | w_nxt_er[p]) ?
                                               w_nxt_data[p*DATA_W +: DATA_W] : '0;
                // Count on the falling edge of rx_dv, in the same cycle it falls
                if (rx_dv[p] && !w_nxt_dv[p] &&
                    frame_cnt[p*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
                    frame_cnt[p*CNT_W +: CNT_W] <= frame_cnt[p*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
            rx_dv <= w_nxt_dv;
            rx_er <= w_nxt_er;
        end
    end

    // Data RAM carries no reset; the flag arrays decide validity
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            r_mem_data[p][r_wr_ptr] <= tx_data[p*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_gmii_link_emulator.sv
// tb/tb_gmii_link_emulator.sv - self-checking bench for gmii_link_emulator
module tb_gmii_link_emulator;

    localparam int NP   = 4;
    localparam int DW   = 8;
    localparam int MD   = 16;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NP*DW-1:0]     tx_data;
    logic [NP-1:0]        tx_en;
    logic [NP-1:0]        tx_er;
    logic [NP*DW-1:0]     rx_data;
    logic [NP-1:0]        rx_dv;
    logic [NP-1:0]        rx_er;
    logic                 cfg_pair_mode;
    logic [3:0]           cfg_delay;
    logic [NP-1:0]        cfg_link_up;
    logic [NP*CW-1:0]     frame_cnt;
    logic                 busy;
`ifdef GMII_LINK_EMU_ERR_INJ_EN
    logic [NP-1:0]        inj_req;
    logic [NP*CW-1:0]     err_cnt;
    logic [NP-1:0]        inj_next;
`endif

    gmii_link_emulator #(
        .NUM_PORTS(NP), .DATA_W(DW), .MAX_DELAY(MD), .CNT_W(CW)
    ) dut (
        .clk(clk), .resetn(resetn),
        .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er),
        .rx_data(rx_data), .rx_dv(rx_dv), .rx_er(rx_er),
        .cfg_pair_mode(cfg_pair_mode), .cfg_delay(cfg_delay), .cfg_link_up(cfg_link_up),
        .frame_cnt(frame_cnt),
`ifdef GMII_LINK_EMU_ERR_INJ_EN
        .inj_req(inj_req), .err_cnt(err_cnt),
`endif
        .busy(busy)
    );

    always #4 clk = ~clk;

    typedef struct packed { logic [7:0] d; logic en; logic er; } ent_t;

    // Reference model: per-source history of written symbols (index 0 = newest)
    ent_t hist [NP][$];
    ent_t txq  [NP][$];
    logic [7:0] m_data [NP];
    bit   m_dv [NP];
    bit   m_er [NP];
    int   m_cnt [NP];
    int   m_delay;
    bit   m_mode;
    bit   m_link [NP];
    int   m_err [NP];
    bit   m_pend [NP];
    int   m_idx [NP];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_n = 0;
    int   tx_rise [NP];
    int   rise [NP][$];
    logic [7:0] cap [NP][$];
    int   er_pos [NP][$];
    bit   prev_dv [NP];

    task automatic chk(input string tag, input int port, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s port=%0d act=%0d exp=%0d cyc=%0d", tag, port, act, exp, cyc_n);
        end
    endtask

    function automatic bit model_busy();
        bit b = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (tx_en[p] || m_dv[p]) b = 1'b1;
            foreach (hist[p][k]) if (hist[p][k].en) b = 1'b1;
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            hist[p].delete();
            for (int k = 0; k < MD; k++) hist[p].push_back('0);
            m_data[p] = '0; m_dv[p] = 0; m_er[p] = 0; m_cnt[p] = 0;
            m_link[p] = 0; m_err[p] = 0; m_pend[p] = 0; m_idx[p] = 0;
        end
        m_delay = 0;
        m_mode  = 0;
    endtask

    task automatic model_step();
        bit   busy_m = model_busy();
        ent_t e;
        int   src;
        bit   ndv, ner;
        logic [7:0] nd;
        for (int s = 0; s < NP; s++) begin
            e.d  = tx_data[s*DW +: DW];
            e.en = tx_en[s] & m_link[s];
            e.er = tx_er[s] & m_link[s];
            hist[s].push_front(e);
            if (hist[s].size() > MD) void'(hist[s].pop_back());
        end
        for (int i = 0; i < NP; i++) begin
            src = m_mode ? i : (i ^ 1);
            e   = hist[src][m_delay];
            nd  = e.d; ndv = e.en; ner = e.er;
`ifdef GMII_LINK_EMU_ERR_INJ_EN
            begin
                int idx = m_dv[i] ? m_idx[i] + 1 : 0;
                if (ndv && m_pend[i] && idx == 8) begin
                    nd[0] = ~nd[0];
                    ner = 1;
                    m_pend[i] = 0;
                    if (m_err[i] < CMAX) m_err[i]++;
                end
                m_idx[i] = idx;
            end
`endif
            if (m_dv[i] && !ndv && m_cnt[i] < CMAX) m_cnt[i]++;
            m_data[i] = nd; m_dv[i] = ndv; m_er[i] = ner;
        end
`ifdef GMII_LINK_EMU_ERR_INJ_EN
        for (int i = 0; i < NP; i++) if (inj_req[i]) m_pend[i] = 1;
`endif
        if (!busy_m) begin
            m_delay = int'(cfg_delay);
            m_mode  = cfg_pair_mode;
        end
        for (int s = 0; s < NP; s++) if (!tx_en[s]) m_link[s] = cfg_link_up[s];
    endtask

    task automatic check_outputs();
        for (int p = 0; p < NP; p++) begin
            chk("rx_dv", p, int'(rx_dv[p]), int'(m_dv[p]));
            chk("rx_er", p, int'(rx_er[p]), int'(m_er[p]));
            if (m_dv[p]) chk("rx_data", p, int'(rx_data[p*DW +: DW]), int'(m_data[p]));
            chk("frame_cnt", p, int'(frame_cnt[p*CW +: CW]), m_cnt[p]);
`ifdef GMII_LINK_EMU_ERR_INJ_EN
            chk("err_cnt", p, int'(err_cnt[p*CW +: CW]), m_err[p]);
`endif
        end
        chk("busy", -1, int'(busy), int'(model_busy()));
    endtask

    task automatic capture();
        for (int p = 0; p < NP; p++) begin
            if (rx_dv[p]) begin
                if (!prev_dv[p]) rise[p].push_back(cyc_n);
                if (rx_er[p]) er_pos[p].push_back(cap[p].size());
                cap[p].push_back(rx_data[p*DW +: DW]);
            end
            prev_dv[p] = rx_dv[p];
        end
    endtask

    task automatic apply_inputs();
        ent_t e;
        for (int p = 0; p < NP; p++) begin
            if (txq[p].size() > 0) begin
                e = txq[p].pop_front();
                if (e.en && !tx_en[p]) tx_rise[p] = cyc_n;
                tx_data[p*DW +: DW] = e.d;
                tx_en[p] = e.en;
                tx_er[p] = e.er;
            end else begin
                tx_data[p*DW +: DW] = 8'($urandom);
                tx_en[p] = 1'b0;
                tx_er[p] = 1'b0;
            end
        end
`ifdef GMII_LINK_EMU_ERR_INJ_EN
        inj_req  = inj_next;
        inj_next = '0;
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        if (resetn) model_step(); else model_reset();
        #1;
        cyc_n++;
        check_outputs();
        capture();
        apply_inputs();
    endtask

    task automatic queue_frame(input int p, input int len, input int start, input int gap);
        for (int k = 0; k < len; k++) txq[p].push_back('{d: 8'(start + k), en: 1'b1, er: 1'b0});
        for (int k = 0; k < gap; k++) txq[p].push_back('{d: 8'h00, en: 1'b0, er: 1'b0});
    endtask

    function automatic bit txq_busy();
        bit b = 1'b0;
        for (int p = 0; p < NP; p++) if (txq[p].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((model_busy() || txq_busy()) && n < 400) begin
            cyc();
            n++;
        end
        chk("idle_timeout", -1, int'(n < 400), 1);
    endtask

    task automatic clear_caps();
        for (int p = 0; p < NP; p++) begin
            cap[p].delete(); rise[p].delete(); er_pos[p].delete();
        end
    endtask

    task automatic set_cfg(input bit mode, input int dly);
        cfg_pair_mode = mode;
        cfg_delay     = 4'(dly);
        wait_idle();
        cyc();
        cyc();
        clear_caps();
    endtask

    task automatic chk_payload(input string tag, input int p, input int off, input int len, input int start);
        int bad = 0;
        for (int k = 0; k < len; k++) begin
            if (off + k >= cap[p].size() || cap[p][off + k] != 8'(start + k)) bad++;
        end
        chk(tag, p, bad, 0);
    endtask

    function automatic int lat(input int dst, input int src);
        return (rise[dst].size() > 0) ? rise[dst][0] - tx_rise[src] : -1;
    endfunction

    typedef struct {
        bit mode;
        int delay;
        int src;
        int len;
        int exp_dst;
        int exp_lat;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [5];
        int   base;
        vt[0] = '{1'b0,  0, 0, 64, 1,  1};
        vt[1] = '{1'b0, 15, 2, 20, 3, 16};
        vt[2] = '{1'b1,  3, 3, 10, 3,  4};
        vt[3] = '{1'b0,  7, 1, 12, 0,  8};
        vt[4] = '{1'b1,  0, 0,  5, 0,  1};

        resetn = 1'b0;
        tx_data = '0; tx_en = '0; tx_er = '0;
        cfg_pair_mode = 1'b0; cfg_delay = '0; cfg_link_up = '1;
`ifdef GMII_LINK_EMU_ERR_INJ_EN
        inj_req = '0; inj_next = '0;
`endif
        for (int p = 0; p < NP; p++) begin prev_dv[p] = 0; tx_rise[p] = 0; end
        model_reset();
        repeat (3) cyc();
        chk("reset_busy", -1, int'(busy), 0);
        chk("reset_rx_dv", -1, int'(rx_dv), 0);
        chk("reset_frame_cnt", -1, int'(frame_cnt != '0), 0);
        resetn = 1'b1;
        cyc();

        // Directed routing/latency table
        for (int v = 0; v < 5; v++) begin
            set_cfg(vt[v].mode, vt[v].delay);
            base = m_cnt[vt[v].exp_dst];
            queue_frame(vt[v].src, vt[v].len, v * 64, 0);
            cyc();
            wait_idle();
            chk("tbl_latency", vt[v].exp_dst, lat(vt[v].exp_dst, vt[v].src), vt[v].exp_lat);
            chk("tbl_len", vt[v].exp_dst, cap[vt[v].exp_dst].size(), vt[v].len);
            chk_payload("tbl_payload", vt[v].exp_dst, 0, vt[v].len, v * 64);
            chk("tbl_cnt", vt[v].exp_dst, int'(frame_cnt[vt[v].exp_dst*CW +: CW]), base + 1);
            if (vt[v].src != vt[v].exp_dst)
                chk("tbl_src_quiet", vt[v].src, cap[vt[v].src].size(), 0);
        end

        // Back-to-back frames with one idle cycle, loopback on port 3
        set_cfg(1'b1, 5);
        base = m_cnt[3];
        queue_frame(3, 8, 8'h80, 1);
        queue_frame(3, 6, 8'h90, 0);
        cyc();
        wait_idle();
        chk("b2b_frames", 3, rise[3].size(), 2);
        if (rise[3].size() == 2) chk("b2b_spacing", 3, rise[3][1] - rise[3][0], 9);
        chk("b2b_len", 3, cap[3].size(), 14);
        chk_payload("b2b_payload1", 3, 0, 8, 8'h80);
        chk_payload("b2b_payload2", 3, 8, 6, 8'h90);
        chk("b2b_cnt", 3, int'(frame_cnt[3*CW +: CW]), base + 2);

        // Delay change mid-frame is deferred until idle
        set_cfg(1'b0, 15);
        queue_frame(2, 30, 8'h40, 0);
        cyc();
        repeat (5) cyc();
        cfg_delay = 4'd4;
        wait_idle();
        chk("midcfg_latency", 3, lat(3, 2), 16);
        chk("midcfg_len", 3, cap[3].size(), 30);
        chk_payload("midcfg_payload", 3, 0, 30, 8'h40);
        cyc(); cyc();
        clear_caps();
        queue_frame(2, 10, 8'h60, 0);
        cyc();
        wait_idle();
        chk("newcfg_latency", 3, lat(3, 2), 5);

        // Link drop mid-frame: frame completes, next one is suppressed
        set_cfg(1'b0, 2);
        queue_frame(0, 20, 8'hA0, 0);
        cyc();
        repeat (5) cyc();
        cfg_link_up[0] = 1'b0;
        wait_idle();
        chk("linkdrop_len", 1, cap[1].size(), 20);
        base = m_cnt[1];
        queue_frame(0, 10, 8'hC0, 0);
        cyc();
        wait_idle();
        chk("linkdown_len", 1, cap[1].size(), 20);
        chk("linkdown_cnt", 1, int'(frame_cnt[1*CW +: CW]), base);
        cfg_link_up = '1;
        cyc(); cyc();

`ifdef GMII_LINK_EMU_ERR_INJ_EN
        set_cfg(1'b0, 0);
        base = m_err[1];
        inj_next[1] = 1'b1;
        queue_frame(0, 6, 8'h10, 2);
        queue_frame(0, 20, 8'h20, 0);
        cyc();
        wait_idle();
        chk("inj_len", 1, cap[1].size(), 26);
        chk_payload("inj_first_clean", 1, 0, 6, 8'h10);
        if (cap[1].size() == 26) chk("inj_byte8", 1, int'(cap[1][14]), 8'h29);
        chk("inj_er_count", 1, er_pos[1].size(), 1);
        if (er_pos[1].size() == 1) chk("inj_er_pos", 1, er_pos[1][0], 14);
        chk("inj_err_cnt", 1, int'(err_cnt[1*CW +: CW]), base + 1);
`endif

        // Asynchronous reset in the middle of a delayed frame
        set_cfg(1'b0, 10);
        queue_frame(0, 40, 8'h00, 0);
        cyc();
        repeat (15) cyc();
        resetn = 1'b0;
        for (int p = 0; p < NP; p++) txq[p].delete();
        tx_en = '0; tx_er = '0;
        #1;
        chk("rst_async_dv", -1, int'(rx_dv), 0);
        chk("rst_async_cnt", -1, int'(frame_cnt != '0), 0);
        model_reset();
        cyc(); cyc();
        resetn = 1'b1;
        clear_caps();
        repeat (40) cyc();
        for (int p = 0; p < NP; p++) begin
            chk("rst_no_residual", p, cap[p].size(), 0);
            chk("rst_cnt_zero", p, int'(frame_cnt[p*CW +: CW]), 0);
        end

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            if ((c % 300) < 250) begin
                for (int p = 0; p < NP; p++) begin
                    if (txq[p].size() == 0 && $urandom_range(0, 9) == 0) begin
                        int len = $urandom_range(1, 24);
                        for (int k = 0; k < len; k++)
                            txq[p].push_back('{d: 8'($urandom), en: 1'b1,
                                               er: ($urandom_range(0, 15) == 0)});
                        for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                            txq[p].push_back('{d: 8'h00, en: 1'b0, er: 1'b0});
                    end
                end
            end
            if ($urandom_range(0, 60) == 0) cfg_delay = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 80) == 0) cfg_pair_mode = 1'($urandom);
            if ($urandom_range(0, 40) == 0) cfg_link_up[$urandom_range(0, NP-1)] ^= 1'b1;
`ifdef GMII_LINK_EMU_ERR_INJ_EN
            if ($urandom_range(0, 50) == 0) inj_next[$urandom_range(0, NP-1)] = 1'b1;
`endif
            cyc();
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
